rpg_lfsr_gen: RTL and testbench

RPG_LFSR_GEN -- requirements
Module: rpg_lfsr_gen

---
 rtl/rpg_lfsr_gen.sv | 149 ++++++++++++++
 tb/tb_rpg_lfsr_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rpg_lfsr_gen.sv
// ---------------------------------------------------------------------------
// rpg_lfsr_gen
// Password generator built around a free-running Galois LFSR. A rising edge
// on unlockDoor, gated by keyEnable, snapshots the LFSR into newPass. A
// snapshot equal to the current password is refused and retried on the next
// cycle. After each generation the block stays busy for MIN_GAP cycles.
//
// States
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for a request edge
//   CAPTURE  | snapshot lfsr into newPass unless it repeats the last one
//   COOLDOWN | post-generation hold-off, cnt counts MIN_GAP..1
//
// Ports
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   keyEnable   request gate
//   unlockDoor  request line, a sampled 0->1 edge is a request
//   seedLoad    load seedIn into the LFSR this cycle (zero maps to SEED)
//   seedIn      seed value
//   newPass     last generated password (registered)
//   passValid   one-cycle pulse when newPass updates
//   busy        high whenever the FSM is outside IDLE
//   reqDropped  one-cycle pulse when a request arrives while busy
// ---------------------------------------------------------------------------
module rpg_lfsr_gen #(
   parameter int unsigned           PASS_WIDTH = 32,
   parameter logic [PASS_WIDTH-1:0] TAPS       = 32'hA3000000,
   parameter logic [PASS_WIDTH-1:0] SEED       = 32'h00000001,
   parameter int unsigned           MIN_GAP    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  keyEnable,
   input  logic                  unlockDoor,
   input  logic                  seedLoad,
   input  logic [PASS_WIDTH-1:0] seedIn,
   output logic [PASS_WIDTH-1:0] newPass,
   output logic                  passValid,
   output logic                  busy,
   output logic                  reqDropped
);

   localparam int unsigned      CNT_W    = $clog2(MIN_GAP + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MIN_GAP);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CAPTURE  = 2'd1,
      COOLDOWN = 2'd2
   } state_t;

   state_t                state;
   state_t                stateNext;
   logic [PASS_WIDTH-1:0] lfsr;
   logic [PASS_WIDTH-1:0] lfsrNext;
   logic                  unlockPrev;
   logic [CNT_W-1:0]      cnt;
   logic                  req;
   logic                  captureHit;
   logic                  dropHit;
   logic                  cntDone;

   // A request is an edge, so holding unlockDoor high yields exactly one.
   assign req     = unlockDoor & ~unlockPrev & keyEnable;
   assign cntDone = (cnt == CNT_ONE);

   // LFSR next value; a load wins over the advance, and a zero seed would
   // lock the register up so it is replaced by SEED.
   always_comb begin
      lfsrNext = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
      if (seedLoad) begin
         lfsrNext = (seedIn == '0) ? SEED : seedIn;
      end
   end

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (req) begin
               stateNext = CAPTURE;
            end
         end
         CAPTURE: begin
            // A repeat keeps us here; the LFSR moves on and we retry.
            if (lfsr != newPass) begin
               stateNext = COOLDOWN;
            end
         end
         COOLDOWN: begin
            if (cntDone) begin
               stateNext = IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // ---------------- output / strobe logic ----------------
   always_comb begin
      busy       = (state != IDLE);
      captureHit = (state == CAPTURE) && (lfsr != newPass);
      dropHit    = req && (state != IDLE);
   end

   // ---------------- datapath registers ----------------
   // unlockPrev resets high so a line already asserted at reset release
   // does not count as a request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr       <= SEED;
         unlockPrev <= 1'b1;
         newPass    <= '0;
         passValid  <= 1'b0;
         reqDropped <= 1'b0;
         cnt        <= '0;
      end else begin
         lfsr       <= lfsrNext;
         unlockPrev <= unlockDoor;
         passValid  <= captureHit;
         reqDropped <= dropHit;
         // Capture uses the value held this cycle, before any load/advance.
         if (captureHit) begin
            newPass <= lfsr;
         end
         if (captureHit) begin
            cnt <= CNT_LOAD;
         end else if ((state == COOLDOWN) && (cnt != '0)) begin
            cnt <= cnt - CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_rpg_lfsr_gen.sv
module tb_rpg_lfsr_gen;

   localparam logic [31:0] TAPS    = 32'hA3000000;
   localparam logic [31:0] SEED    = 32'h00000001;
   localparam int          MIN_GAP = 4;
   localparam int          NVEC    = 28;
   localparam int          NRAND   = 10000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        keyEnable = 1'b1;
   logic        unlockDoor = 1'b0;
   logic        seedLoad = 1'b0;
   logic [31:0] seedIn = 32'h0;
   logic [31:0] newPass;
   logic        passValid;
   logic        busy;
   logic        reqDropped;

   int tests = 0;
   int fails = 0;

   rpg_lfsr_gen #(
      .PASS_WIDTH(32),
      .TAPS(TAPS),
      .SEED(SEED),
      .MIN_GAP(MIN_GAP)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .keyEnable(keyEnable),
      .unlockDoor(unlockDoor),
      .seedLoad(seedLoad),
      .seedIn(seedIn),
      .newPass(newPass),
      .passValid(passValid),
      .busy(busy),
      .reqDropped(reqDropped)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Tracks the password generator as a few plain variables: the LFSR value,
   // whether a capture is pending, and how many hold-off cycles remain.
   logic [31:0] mLfsr, mPass, mPrevPass;
   logic        mPrev, mCapt, mPv, mDrop;
   int          mCool;

   function automatic logic [31:0] lfsrStep(input logic [31:0] x);
      return (x >> 1) ^ (x[0] ? TAPS : 32'h0);
   endfunction

   task automatic modelReset();
      mLfsr = SEED; mPass = 32'h0; mPrevPass = 32'h0;
      mPrev = 1'b1; mCapt = 1'b0; mPv = 1'b0; mDrop = 1'b0; mCool = 0;
   endtask

   task automatic modelClock(input logic ud, input logic ke, input logic sl, input logic [31:0] seed);
      logic rq;
      logic bz;
      rq = ud && !mPrev && ke;
      bz = mCapt || (mCool > 0);
      mDrop = rq && bz;
      mPv = 1'b0;
      if (mCapt) begin
         if (mLfsr != mPass) begin
            mPrevPass = mPass;
            mPass = mLfsr;
            mPv = 1'b1;
            mCapt = 1'b0;
            mCool = MIN_GAP;
         end
      end else if (mCool > 0) begin
         mCool = mCool - 1;
      end else if (rq) begin
         mCapt = 1'b1;
      end
      mLfsr = sl ? ((seed == 32'h0) ? SEED : seed) : lfsrStep(mLfsr);
      mPrev = ud;
   endtask

   // Drive inputs, clock once, sample outputs 1 time unit after the edge.
   task automatic step(input logic ud, input logic ke, input logic sl, input logic [31:0] seed);
      unlockDoor = ud; keyEnable = ke; seedLoad = sl; seedIn = seed;
      @(posedge clk);
      modelClock(ud, ke, sl, seed);
      #1;
   endtask

   task automatic applyReset(input logic udLevel);
      unlockDoor = udLevel; keyEnable = 1'b1; seedLoad = 1'b0; seedIn = 32'h0;
      rst_n = 1'b0;
      modelReset();
      #1;
      check("rst_newPass", newPass, 32'h0);
      check("rst_passValid", 32'(passValid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_reqDropped", 32'(reqDropped), 32'h0);
      repeat (2) begin
         @(posedge clk);
         #1;
         check("rst_hold_passValid", 32'(passValid), 32'h0);
         check("rst_hold_newPass", newPass, 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic        ud, ke, sl;
      logic [31:0] seed;
      logic        pv, bz, drop;
      logic [31:0] pass;
   } vec_t;

   vec_t vecs[NVEC];

   function automatic vec_t mk(input logic ud, input logic ke, input logic sl, input logic [31:0] seed,
                               input logic pv, input logic bz, input logic drop, input logic [31:0] pass);
      vec_t v;
      v.ud = ud; v.ke = ke; v.sl = sl; v.seed = seed;
      v.pv = pv; v.bz = bz; v.drop = drop; v.pass = pass;
      return v;
   endfunction

   initial begin
      logic        rUd, rKe, rSl;
      logic [31:0] rSeed;

      //                ud    ke    sl    seedIn          pv    busy  drop  newPass
      vecs[0]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0);
      vecs[1]  = mk(1'b1, 1'b1, 1'b1, 32'hA3000000, 1'b0, 1'b1, 1'b0, 32'h0);
      vecs[2]  = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'hA3000000);
      vecs[3]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'hA3000000);
      vecs[4]  = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hA3000000);
      vecs[5]  = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'hA3000000);
      vecs[6]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'hA3000000);
      vecs[7]  = mk(1'b1, 1'b1, 1'b1, 32'hA3000000, 1'b0, 1'b1, 1'b0, 32'hA3000000);
      vecs[8]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'hA3000000);
      vecs[9]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h51800000);
      vecs[10] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h51800000);
      vecs[11] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h51800000);
      vecs[12] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h51800000);
      vecs[13] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h51800000);
      vecs[14] = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h51800000);
      vecs[15] = mk(1'b0, 1'b1, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h51800000);
      vecs[16] = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h51800000);
      vecs[17] = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'hA3000000);
      vecs[18] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'hA3000000);
      vecs[19] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'hA3000000);
      vecs[20] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'hA3000000);
      vecs[21] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'hA3000000);
      vecs[22] = mk(1'b1, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'hA3000000);
      vecs[23] = mk(1'b0, 1'b1, 1'b1, 32'h0F0F0F0F, 1'b1, 1'b1, 1'b0, 32'h12345678);
      vecs[24] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h12345678);
      vecs[25] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h12345678);
      vecs[26] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h12345678);
      vecs[27] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h12345678);

      #2;

      // unlockDoor high across reset release must not start a generation.
      applyReset(1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0);
         check($sformatf("held_busy%0d", i), 32'(busy), 32'h0);
         check($sformatf("held_pv%0d", i), 32'(passValid), 32'h0);
      end

      // Directed table: capture, drop while busy, repeat rejection,
      // zero seed, keyEnable gating/falling, seed load during CAPTURE.
      for (int i = 0; i < NVEC; i++) begin
         step(vecs[i].ud, vecs[i].ke, vecs[i].sl, vecs[i].seed);
         check($sformatf("vec%0d_passValid", i), 32'(passValid), 32'(vecs[i].pv));
         check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].bz));
         check($sformatf("vec%0d_reqDropped", i), 32'(reqDropped), 32'(vecs[i].drop));
         check($sformatf("vec%0d_newPass", i), newPass, vecs[i].pass);
      end

      // Reset in the middle of COOLDOWN.
      step(1'b1, 1'b1, 1'b1, 32'hCAFEF00D);
      check("cool_enter_busy", 32'(busy), 32'h1);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      check("cool_capture_pv", 32'(passValid), 32'h1);
      check("cool_capture_pass", newPass, 32'hCAFEF00D);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      check("cool_mid_busy", 32'(busy), 32'h1);
      applyReset(1'b0);

      // Reset while in CAPTURE: the pending capture is abandoned.
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 32'hDEADBEEF);
      check("capt_busy", 32'(busy), 32'h1);
      applyReset(1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, 32'h0);
         check($sformatf("capt_after_pv%0d", i), 32'(passValid), 32'h0);
         check($sformatf("capt_after_busy%0d", i), 32'(busy), 32'h0);
         check($sformatf("capt_after_pass%0d", i), newPass, 32'h0);
      end

      // Randomised run against the reference model.
      applyReset(1'b0);
      for (int c = 0; c < NRAND; c++) begin
         rUd = 1'($urandom_range(0, 1));
         rKe = ($urandom_range(0, 7) != 0);
         rSl = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 3))
            0:       rSeed = 32'h0;
            1:       rSeed = mPass;
            default: rSeed = $urandom;
         endcase
         step(rUd, rKe, rSl, rSeed);
         check("rnd_passValid", 32'(passValid), 32'(mPv));
         check("rnd_busy", 32'(busy), 32'(mCapt || (mCool > 0)));
         check("rnd_reqDropped", 32'(reqDropped), 32'(mDrop));
         check("rnd_newPass", newPass, mPass);
         if (mPv) begin
            check("rnd_no_repeat", 32'(newPass == mPrevPass), 32'h0);
            if (mPrevPass != 32'h0) begin
               check("rnd_no_zero", 32'(newPass == 32'h0), 32'h0);
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
